// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: dot-product sequencer for one multiply-only MAC block.
// Latches a (mode, length) command, streams operand beats into the registered
// MAC inputs, accumulates each product and returns the sum on a valid/ready port.
// Optional feature: define MAC_ACC_SAT_EN for a saturating accumulator with a
// sticky res_sat flag; otherwise the accumulator wraps and res_sat is tied 0.
`timescale 1ns/1ps

`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_INT_WIDTH
`define MAC_INT_WIDTH 40
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 2
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'b00
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

// One A lane register: loads the routed lane on a beat, or 0 if the mode leaves it unused.
module mac_seq_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         use_lane,
  input  logic [W-1:0] src,
  output logic [W-1:0] q
);
  // Lane register, held between beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (ld) q <= use_lane ? src : '0;
  end
endmodule

module mac_seq_ctrl #(
  parameter int MIN_W = `MAC_MIN_WIDTH,
  parameter int INT_W = `MAC_INT_WIDTH,
  parameter int ACC_W = 48,
  parameter int LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_mode,
  input  logic [LEN_W-1:0]           cmd_len,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [4*MIN_W-1:0]         op_a,
  input  logic [MIN_W-1:0]           op_b,
  output logic [`MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic [MIN_W-1:0]           mac_a0,
  output logic [MIN_W-1:0]           mac_a1,
  output logic [MIN_W-1:0]           mac_a2,
  output logic [MIN_W-1:0]           mac_a3,
  output logic [MIN_W-1:0]           mac_b1,
  input  logic [INT_W-1:0]           mac_c,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_data,
  output logic                       res_err,
  output logic                       res_sat,
  output logic                       busy
);
  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_DUAL   = 2'd1;
  localparam logic [1:0] M_QUAD   = 2'd2;
  localparam logic [1:0] M_RSVD   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [LEN_W-1:0] len;
  } cmd_t;

  state_t                  state_q, state_d;
  cmd_t                    cmd_q;
  logic [LEN_W-1:0]        count_q;
  logic [LEN_W-1:0]        count_inc;
  logic                    pipe_v;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_next;
  logic                    cmd_fire, op_fire, last_beat;
  logic [3:0]              lane_use;
  logic [3:0][MIN_W-1:0]   lane_src;
  logic [3:0][MIN_W-1:0]   lane_q;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  assign count_inc = count_q + LEN_W'(1);
  assign last_beat = op_fire && (count_inc == cmd_q.len);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_fire)
          state_d = (cmd_len == '0 || cmd_mode == M_RSVD) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        op_ready = (count_q < cmd_q.len);
        if (last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, beat counter and product-valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q   <= '0;
      count_q <= '0;
      pipe_v  <= 1'b0;
    end else begin
      pipe_v <= op_fire;
      if (cmd_fire) begin
        cmd_q   <= '{mode: cmd_mode, len: cmd_len};
        count_q <= '0;
      end else if (op_fire) begin
        count_q <= count_inc;
      end
    end
  end

  // MAC mode register: set per command, left alone by reserved commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mac_cfg <= '0;
    else if (cmd_fire) begin
      case (cmd_mode)
        M_SINGLE: mac_cfg <= `MAC_SINGLE;
        M_DUAL:   mac_cfg <= `MAC_DUAL;
        M_QUAD:   mac_cfg <= `MAC_QUAD;
        default:  mac_cfg <= mac_cfg;
      endcase
    end
  end

  // B operand register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mac_b1 <= '0;
    else if (op_fire) mac_b1 <= op_b;
  end

  // Lane routing: SINGLE feeds lane 0 into A1; unused lanes are zeroed.
  always_comb begin
    for (int i = 0; i < 4; i++) lane_src[i] = op_a[i*MIN_W +: MIN_W];
    lane_use = 4'b0000;
    case (cmd_q.mode)
      M_SINGLE: begin
        lane_use    = 4'b0010;
        lane_src[1] = op_a[0 +: MIN_W];
      end
      M_DUAL:  lane_use = 4'b0011;
      M_QUAD:  lane_use = 4'b1111;
      default: lane_use = 4'b0000;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mac_seq_lane #(.W(MIN_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld       (op_fire),
      .use_lane (lane_use[i]),
      .src      (lane_src[i]),
      .q        (lane_q[i])
    );
  end

  assign mac_a0 = lane_q[0];
  assign mac_a1 = lane_q[1];
  assign mac_a2 = lane_q[2];
  assign mac_a3 = lane_q[3];

`ifdef MAC_ACC_SAT_EN
  // Wide enough to hold either operand plus a carry.
  localparam int SUM_W = ((ACC_W > INT_W) ? ACC_W : INT_W) + 1;
  logic [SUM_W-1:0] sum;
  logic             ovf;
  logic             sat_q;

  // Clamp to all-ones whenever the add leaves the accumulator range.
  always_comb begin
    sum      = SUM_W'(acc_q) + SUM_W'(mac_c);
    ovf      = |sum[SUM_W-1:ACC_W];
    acc_next = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // Sticky saturation flag, cleared when a new command is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                sat_q <= 1'b0;
    else if (cmd_fire)       sat_q <= 1'b0;
    else if (pipe_v && ovf)  sat_q <= 1'b1;
  end

  assign res_sat = (state_q == S_DONE) & sat_q;
`else
  // Plain modulo-2^ACC_W accumulate.
  always_comb acc_next = acc_q + ACC_W'(mac_c);

  assign res_sat = 1'b0;
`endif

  // Accumulator: cleared per command, adds the product one cycle after each beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          acc_q <= '0;
    else if (cmd_fire) acc_q <= '0;
    else if (pipe_v)   acc_q <= acc_next;
  end

  assign res_err  = (state_q == S_DONE) && (cmd_q.mode == M_RSVD);
  assign res_data = (state_q == S_DONE && cmd_q.mode != M_RSVD) ? acc_q : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed table-driven bench for mac_seq_ctrl: a 48-bit and a 16-bit
// accumulator instance run in lock-step, each driven by a behavioural MAC.
`timescale 1ns/1ps

`ifndef MAC_SINGLE
`define MAC_SINGLE 2'b00
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module tb_mac_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, op_valid = 0, res_ready = 0;
  logic [1:0]  cmd_mode = 0;
  logic [7:0]  cmd_len = 0;
  logic [31:0] op_a = 0;
  logic [7:0]  op_b = 0;

  logic        cmd_ready, op_ready, res_valid, res_err, res_sat, busy;
  logic [1:0]  mac_cfg;
  logic [7:0]  mac_a0, mac_a1, mac_a2, mac_a3, mac_b1;
  logic [39:0] mac_c;
  logic [47:0] res_data;

  logic        n_cmd_ready, n_op_ready, n_res_valid, n_res_err, n_res_sat, n_busy;
  logic [1:0]  n_mac_cfg;
  logic [7:0]  n_mac_a0, n_mac_a1, n_mac_a2, n_mac_a3, n_mac_b1;
  logic [39:0] n_mac_c;
  logic [15:0] n_res_data;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural MAC product for the three modes.
  function automatic logic [39:0] mac_model(input logic [1:0] cfg,
      input logic [7:0] a0, a1, a2, a3, b);
    case (cfg)
      `MAC_SINGLE: return 40'(a1) * 40'(b);
      `MAC_DUAL:   return 40'({a1, a0}) * 40'(b);
      `MAC_QUAD:   return 40'({a3, a2, a1, a0}) * 40'(b);
      default:     return 40'd0;
    endcase
  endfunction

  assign mac_c   = mac_model(mac_cfg, mac_a0, mac_a1, mac_a2, mac_a3, mac_b1);
  assign n_mac_c = mac_model(n_mac_cfg, n_mac_a0, n_mac_a1, n_mac_a2, n_mac_a3, n_mac_b1);

  mac_seq_ctrl #(.MIN_W(8), .INT_W(40), .ACC_W(48), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .mac_cfg(mac_cfg), .mac_a0(mac_a0), .mac_a1(mac_a1),
    .mac_a2(mac_a2), .mac_a3(mac_a3), .mac_b1(mac_b1), .mac_c(mac_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_sat(res_sat), .busy(busy)
  );

  mac_seq_ctrl #(.MIN_W(8), .INT_W(40), .ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .op_valid(op_valid), .op_ready(n_op_ready),
    .op_a(op_a), .op_b(op_b), .mac_cfg(n_mac_cfg), .mac_a0(n_mac_a0), .mac_a1(n_mac_a1),
    .mac_a2(n_mac_a2), .mac_a3(n_mac_a3), .mac_b1(n_mac_b1), .mac_c(n_mac_c),
    .res_valid(n_res_valid), .res_ready(res_ready), .res_data(n_res_data),
    .res_err(n_res_err), .res_sat(n_res_sat), .busy(n_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       mode;
    int               len;
    logic [2:0][31:0] a;
    logic [2:0][7:0]  b;
    int               gap;
    int               hold;
    logic [47:0]      exp_data;
    logic             exp_err;
    logic [1:0]       exp_cfg;
    logic [15:0]      exp16;
    logic             exp_sat16;
    logic             lanes_chk;
    logic [31:0]      exp_lanes;
    int               exp_edges;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] mode, input int len,
      input logic [31:0] a0, a1, a2, input logic [7:0] b0, b1, b2,
      input int gap, input int hold, input logic [47:0] exp_data,
      input logic [1:0] exp_cfg, input logic [15:0] exp16, input logic exp_sat16,
      input logic lanes_chk, input logic [31:0] exp_lanes);
    vec_t v;
    v.mode = mode;  v.len = len;
    v.a[0] = a0;  v.a[1] = a1;  v.a[2] = a2;
    v.b[0] = b0;  v.b[1] = b1;  v.b[2] = b2;
    v.gap = gap;  v.hold = hold;
    v.exp_data = exp_data;
    v.exp_err = (mode == 2'd3);
    v.exp_cfg = exp_cfg;
    v.exp16 = exp16;  v.exp_sat16 = exp_sat16;
    v.lanes_chk = lanes_chk;  v.exp_lanes = exp_lanes;
    v.exp_edges = (len == 0 || mode == 2'd3) ? 0 : 1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int   cyc;
    logic saw_op;
    logic stable;
    saw_op = 1'b0;
    cmd_mode = v.mode;  cmd_len = 8'(v.len);  cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin tick(); cyc++; end
    chk($sformatf("v%0d_cmd_ready", k), cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    if (v.mode == 2'd3) begin
      // Offer a beat anyway: it must never be taken.
      op_a = 32'hDEADBEEF;  op_b = 8'h55;  op_valid = 1'b1;
    end else begin
      for (int i = 0; i < v.len; i++) begin
        op_valid = 1'b0;
        repeat (v.gap) tick();
        op_a = v.a[i];  op_b = v.b[i];  op_valid = 1'b1;
        cyc = 0;
        while (!op_ready && cyc < 50) begin tick(); cyc++; end
        chk($sformatf("v%0d_op_ready_b%0d", k, i), op_ready, 1'b1);
        tick();
      end
      op_valid = 1'b0;
    end
    cyc = 0;
    saw_op |= op_ready;
    while (!res_valid && cyc < 50) begin tick(); cyc++; saw_op |= op_ready; end
    chk($sformatf("v%0d_latency", k), 64'(cyc), 64'(v.exp_edges));
    chk($sformatf("v%0d_res_data", k), res_data, v.exp_data);
    chk($sformatf("v%0d_res_err", k), res_err, v.exp_err);
    chk($sformatf("v%0d_res_sat", k), res_sat, 1'b0);
    chk($sformatf("v%0d_res16_valid", k), n_res_valid, 1'b1);
    chk($sformatf("v%0d_res16_data", k), n_res_data, v.exp16);
    chk($sformatf("v%0d_res16_sat", k), n_res_sat, v.exp_sat16);
    if (!v.exp_err) chk($sformatf("v%0d_mac_cfg", k), mac_cfg, v.exp_cfg);
    if (v.lanes_chk)
      chk($sformatf("v%0d_lanes", k), {mac_a3, mac_a2, mac_a1, mac_a0}, v.exp_lanes);
    if (v.hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        saw_op |= op_ready;
        if (!(res_valid === 1'b1 && res_data === v.exp_data && res_err === v.exp_err))
          stable = 1'b0;
      end
      chk($sformatf("v%0d_hold_stable", k), stable, 1'b1);
    end
    if (v.mode == 2'd3) chk($sformatf("v%0d_no_op_ready", k), saw_op, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    op_valid  = 1'b0;
    chk($sformatf("v%0d_res_valid_clr", k), res_valid, 1'b0);
    chk($sformatf("v%0d_cmd_ready_back", k), cmd_ready, 1'b1);
  endtask

  vec_t tbl[7];
  logic [15:0] q16, s16;
  logic        qs, ss;

  initial begin
`ifdef MAC_ACC_SAT_EN
    q16 = 16'hFFFF;  qs = 1'b1;  s16 = 16'hFFFF;  ss = 1'b1;
`else
    q16 = 16'h0608;  qs = 1'b0;  s16 = 16'd64514; ss = 1'b0;
`endif
    tbl[0] = mk(2'd0, 3, 32'd2, 32'd4, 32'd6, 8'd3, 8'd5, 8'd7, 0, 5, 48'd68,
                `MAC_SINGLE, 16'd68, 1'b0, 1'b1, 32'h0000_0600);
    tbl[1] = mk(2'd1, 2, 32'h0102, 32'h0102, 32'h0, 8'd3, 8'd3, 8'd0, 0, 0, 48'd1548,
                `MAC_DUAL, 16'd1548, 1'b0, 1'b1, 32'h0000_0102);
    tbl[2] = mk(2'd2, 1, 32'h01020304, 32'h0, 32'h0, 8'd2, 8'd0, 8'd0, 0, 0, 48'h02040608,
                `MAC_QUAD, q16, qs, 1'b1, 32'h01020304);
    tbl[3] = mk(2'd2, 1, 32'h01020304, 32'h0, 32'h0, 8'd2, 8'd0, 8'd0, 3, 0, 48'h02040608,
                `MAC_QUAD, q16, qs, 1'b1, 32'h01020304);
    tbl[4] = mk(2'd0, 0, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 0, 0, 48'd0,
                `MAC_SINGLE, 16'd0, 1'b0, 1'b0, 32'h0);
    tbl[5] = mk(2'd3, 5, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 0, 3, 48'd0,
                `MAC_SINGLE, 16'd0, 1'b0, 1'b0, 32'h0);
    tbl[6] = mk(2'd0, 2, 32'd255, 32'd255, 32'h0, 8'd255, 8'd255, 8'd0, 0, 0, 48'd130050,
                `MAC_SINGLE, s16, ss, 1'b1, 32'h0000_FF00);

    // Reset values while rst is held low.
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_op_ready", op_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_data", res_data, 48'd0);
    chk("rst_mac_regs", {mac_cfg, mac_a3, mac_a2, mac_a1, mac_a0, mac_b1}, 42'd0);
    #20;
    rst = 1'b1;
    tick();

    // Operand beats offered in IDLE are ignored.
    op_a = 32'hFFFF_FFFF;  op_b = 8'hFF;  op_valid = 1'b1;
    tick();
    tick();
    chk("idle_op_ready", op_ready, 1'b0);
    chk("idle_mac_regs", {mac_a1, mac_b1}, 16'd0);
    op_valid = 1'b0;

    // Command during busy is ignored; reset mid-RUN returns to IDLE.
    cmd_mode = 2'd0;  cmd_len = 8'd3;  cmd_valid = 1'b1;
    tick();
    cmd_mode = 2'd2;
    op_a = 32'd9;  op_b = 8'd9;  op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    chk("run_busy", busy, 1'b1);
    chk("run_cmd_ready", cmd_ready, 1'b0);
    chk("run_mac_cfg", mac_cfg, `MAC_SINGLE);
    chk("run_mac_a1", mac_a1, 8'd9);
    cmd_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_mac_a1", mac_a1, 8'd0);
    #12;
    rst = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) run_vec(k, tbl[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule
